bcd_output: RTL and testbench

Seven-segment display driver stage for the board's 4-digit multiplexed display. It converts one 4-bit digit value into a 7-segment pattern and forwards the matching active-low anode select. The data memory's digit scanner presents one digit per clock. This block registers the decoded pattern and the anode together so they always change on the same edge and the display never ghosts.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_lut.sv | 22 ++
 rtl/bcd_output.sv | 39 +++
 tb/tb_bcd_output.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low {g,f,e,d,c,b,a} codes for 0-F,
// the blank pattern and the all-digits-off anode select.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANN_OFF   = 4'b1111;

  // Index 0 is the rightmost element, so entry n is the code for value n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

endpackage

// File: rtl/seg7_lut.sv
// Combinational 4-bit value to 7-segment decoder with selectable hex glyphs
// and segment polarity.
module seg7_lut
  import seg7_pkg::*;
#(
  parameter int HEX_EN         = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] num,
  output logic [6:0] seg
);

  logic [6:0] code;

  always_comb begin
    code = SEG_TABLE[num];
    if (HEX_EN == 0 && num > 4'd9) code = SEG_BLANK;
    // Table is stored active-low; common-cathode boards just invert it.
    seg = (SEG_ACTIVE_LOW != 0) ? code : ~code;
  end

endmodule

// File: rtl/bcd_output.sv
// Display driver stage: decodes one digit per clock and registers the pattern
// together with its anode select so both change on the same edge.
module bcd_output
  import seg7_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int HEX_EN         = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] din_num,
  input  logic [3:0] din_anns,
  output logic [6:0] dout,
  output logic [3:0] dout_ann
);

  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;

  logic [6:0] seg;

  seg7_lut #(
    .HEX_EN         (HEX_EN),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_lut (
    .num (din_num),
    .seg (seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dout     <= SEG_OFF;
      dout_ann <= ANN_OFF;
    end else begin
      dout     <= seg;
      dout_ann <= din_anns;
    end
  end

endmodule

// File: tb/tb_bcd_output.sv
// Bench for bcd_output: directed vector table plus randomized traffic checked
// against a lit-segment model, across default, no-hex and common-cathode builds.
module tb_bcd_output;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din_num;
  logic [3:0] din_anns;
  logic [6:0] dout, dout_nh, dout_cc;
  logic [3:0] dout_ann, ann_nh, ann_cc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_output u_dut (
    .clk(clk), .reset(reset), .din_num(din_num), .din_anns(din_anns),
    .dout(dout), .dout_ann(dout_ann)
  );

  bcd_output #(.HEX_EN(0)) u_nohex (
    .clk(clk), .reset(reset), .din_num(din_num), .din_anns(din_anns),
    .dout(dout_nh), .dout_ann(ann_nh)
  );

  bcd_output #(.SEG_ACTIVE_LOW(0)) u_cc (
    .clk(clk), .reset(reset), .din_num(din_num), .din_anns(din_anns),
    .dout(dout_cc), .dout_ann(ann_cc)
  );

  typedef struct {
    logic       rst;
    logic [3:0] num;
    logic [3:0] anns;
    logic [6:0] exp_dout;   // default build, active-low
    logic [3:0] exp_ann;
    logic [6:0] exp_nohex;  // HEX_EN=0 build
  } vec_t;

  vec_t vecs[$];

  // Which segments glow for each value, by letter; polarity applied afterwards.
  function automatic logic [6:0] seg_model(int v, bit hex_en, bit active_low);
    string      lit;
    logic [6:0] pat;
    case (v)
      0: lit = "abcdef";   1: lit = "bc";      2: lit = "abdeg";
      3: lit = "abcdg";    4: lit = "bcfg";    5: lit = "acdfg";
      6: lit = "acdefg";   7: lit = "abc";     8: lit = "abcdefg";
      9: lit = "abcdfg";   10: lit = "abcefg"; 11: lit = "cdefg";
      12: lit = "adef";    13: lit = "bcdeg";  14: lit = "adefg";
      default: lit = "aefg";
    endcase
    if (!hex_en && v > 9) lit = "";
    pat = 7'h7F;
    for (int i = 0; i < lit.len(); i++) pat[int'(lit[i]) - 97] = 1'b0;
    return active_low ? pat : ~pat;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] num, input logic [3:0] anns);
    reset    = rst;
    din_num  = num;
    din_anns = anns;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic [3:0] num, input logic [3:0] anns,
                     input logic [6:0] ed, input logic [3:0] ea, input logic [6:0] enh);
    vec_t v;
    v.rst = rst; v.num = num; v.anns = anns;
    v.exp_dout = ed; v.exp_ann = ea; v.exp_nohex = enh;
    vecs.push_back(v);
  endtask

  initial begin
    logic [6:0] sweep [16];
    logic [3:0] scan_a [4];
    logic [3:0] scan_d [4];
    logic [6:0] scan_e [4];
    sweep = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    scan_a = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    scan_d = '{4'd3, 4'd9, 4'd7, 4'd5};
    scan_e = '{7'h30, 7'h10, 7'h78, 7'h12};

    // Reset held two cycles, then release loads the waiting inputs.
    add(1, 8, 4'b1110, 7'h7F, 4'b1111, 7'h7F);
    add(1, 8, 4'b1110, 7'h7F, 4'b1111, 7'h7F);
    add(0, 8, 4'b1110, 7'h00, 4'b1110, 7'h00);
    for (int i = 0; i < 16; i++)
      add(0, 4'(i), 4'b1110, sweep[i], 4'b1110, (i > 9) ? 7'h7F : sweep[i]);
    for (int i = 0; i < 4; i++)
      add(0, scan_d[i], scan_a[i], scan_e[i], scan_a[i], scan_e[i]);
    // One-cycle reset mid-scan, then scanning resumes.
    add(1, 3, 4'b1110, 7'h7F, 4'b1111, 7'h7F);
    add(0, 9, 4'b1101, 7'h10, 4'b1101, 7'h10);
    add(0, 12, 4'b0101, 7'h46, 4'b0101, 7'h7F);
    add(0, 1, 4'b0000, 7'h79, 4'b0000, 7'h79);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].num, vecs[i].anns);
      chk($sformatf("vec%0d dout", i), {1'b0, dout}, {1'b0, vecs[i].exp_dout});
      chk($sformatf("vec%0d dout_ann", i), {4'b0, dout_ann}, {4'b0, vecs[i].exp_ann});
      chk($sformatf("vec%0d nohex", i), {1'b0, dout_nh}, {1'b0, vecs[i].exp_nohex});
      chk($sformatf("vec%0d cc", i), {1'b0, dout_cc}, {1'b0, ~vecs[i].exp_dout});
    end

    // Hand sequence: common-cathode build, digit 1 then reset blank.
    step(0, 1, 4'b1011);
    chk("cc digit1", {1'b0, dout_cc}, 8'h06);
    chk("cc ann", {4'b0, ann_cc}, 8'h0B);
    step(1, 1, 4'b1011);
    chk("cc reset", {1'b0, dout_cc}, 8'h00);
    chk("cc reset ann", {4'b0, ann_cc}, 8'h0F);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 300; n++) begin
      logic       r;
      logic [3:0] d, a;
      r = ($urandom_range(0, 15) == 0);
      d = 4'($urandom_range(0, 15));
      a = 4'($urandom_range(0, 15));
      step(r, d, a);
      chk("rnd dout", {1'b0, dout}, {1'b0, r ? 7'h7F : seg_model(int'(d), 1, 1)});
      chk("rnd ann", {4'b0, dout_ann}, {4'b0, r ? 4'b1111 : a});
      chk("rnd nohex", {1'b0, dout_nh}, {1'b0, r ? 7'h7F : seg_model(int'(d), 0, 1)});
      chk("rnd cc", {1'b0, dout_cc}, {1'b0, r ? 7'h00 : seg_model(int'(d), 1, 0)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
